// File: rtl/uart_rx_line_assembler.sv
// Assembles received UART bytes into a fixed-width ASCII line terminated by CR LF.
// A working buffer keeps collecting while the published line waits for acknowledgement.
module uart_rx_line_assembler #(
    parameter int parm_ascii_line_length = 35
) (
    input  logic                                  i_clk_40mhz,
    input  logic                                  i_rst_40mhz_n,
    input  logic [7:0]                            i_rx_data,
    input  logic                                  i_rx_valid,
    output logic [8*parm_ascii_line_length-1:0]   o_dat_ascii_line,
    output logic                                  o_line_valid,
    input  logic                                  i_line_ack,
    output logic                                  o_line_trunc,
    output logic                                  o_line_lost
);

    localparam int N = parm_ascii_line_length;
    localparam logic [5:0] CAP = 6'(N - 2);
    localparam logic [8*N-1:0] BLANK_WORK = {N{8'h20}};
    localparam logic [8*N-1:0] BLANK_LINE = {{(N - 2){8'h20}}, 16'h0D0A};

    typedef enum logic {
        ST_RXLINE_COLL,
        ST_RXLINE_DISC
    } state_t;

    state_t           state;
    logic [8*N-1:0]   work_line;
    logic [5:0]       work_cnt;
    logic             work_trunc;

    logic             lf_p0;
    logic             publish_p0;
    logic             drop_p0;
    logic [8*N-1:0]   image_p0;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic is_backspace(input logic [7:0] b);
        return (b == 8'h08) || (b == 8'h7F);
    endfunction

    // Byte index 0 sits in the most significant byte lane.
    function automatic logic [8*N-1:0] put_byte(input logic [8*N-1:0] line,
                                                input logic [5:0]     idx,
                                                input logic [7:0]     b);
        logic [8*N-1:0] res;
        res = line;
        for (int i = 0; i < N; i++) begin
            if (idx == 6'(i)) begin
                res[8*(N-1-i) +: 8] = b;
            end
        end
        return res;
    endfunction

    // Stage p0: decode the incoming strobe against the output handshake
    always_comb begin
        lf_p0      = i_rx_valid && (i_rx_data == 8'h0A);
        publish_p0 = lf_p0 && (!o_line_valid || i_line_ack);
        drop_p0    = lf_p0 && o_line_valid && !i_line_ack;
        image_p0   = {work_line[8*N-1:16], 16'h0D0A};
    end

    // Stage p1: working buffer, collection FSM and registered outputs
    always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n) begin
        if (!i_rst_40mhz_n) begin
            state            <= ST_RXLINE_COLL;
            work_line        <= BLANK_WORK;
            work_cnt         <= 6'd0;
            work_trunc       <= 1'b0;
            o_dat_ascii_line <= BLANK_LINE;
            o_line_valid     <= 1'b0;
            o_line_trunc     <= 1'b0;
            o_line_lost      <= 1'b0;
        end else begin
            o_line_lost <= drop_p0;

            if (publish_p0) begin
                o_dat_ascii_line <= image_p0;
                o_line_trunc     <= work_trunc;
                o_line_valid     <= 1'b1;
            end else if (o_line_valid && i_line_ack) begin
                o_line_valid <= 1'b0;
            end

            if (lf_p0) begin
                state      <= ST_RXLINE_COLL;
                work_line  <= BLANK_WORK;
                work_cnt   <= 6'd0;
                work_trunc <= 1'b0;
            end else if (i_rx_valid && (state == ST_RXLINE_COLL)) begin
                if (is_backspace(i_rx_data)) begin
                    if (work_cnt != 6'd0) begin
                        work_cnt  <= work_cnt - 6'd1;
                        work_line <= put_byte(work_line, work_cnt - 6'd1, 8'h20);
                    end
                end else if (is_printable(i_rx_data)) begin
                    if (work_cnt < CAP) begin
                        work_cnt  <= work_cnt + 6'd1;
                        work_line <= put_byte(work_line, work_cnt, i_rx_data);
                    end else begin
                        // Overflowing byte is dropped; the rest of the line is discarded until LF.
                        work_trunc <= 1'b1;
                        state      <= ST_RXLINE_DISC;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_line_assembler.sv
// Directed vector bench for uart_rx_line_assembler: table of per-cycle stimulus and
// expected outputs, plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_uart_rx_line_assembler;

  localparam int N = 35;

  logic           clk;
  logic           rst_n;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [8*N-1:0] line;
  logic           line_valid;
  logic           line_ack;
  logic           line_trunc;
  logic           line_lost;

  int n_vec;
  int n_miss;

  uart_rx_line_assembler #(.parm_ascii_line_length(N)) dut (
    .i_clk_40mhz      (clk),
    .i_rst_40mhz_n    (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_dat_ascii_line (line),
    .o_line_valid     (line_valid),
    .i_line_ack       (line_ack),
    .o_line_trunc     (line_trunc),
    .o_line_lost      (line_lost)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  typedef struct {
    logic           vld;
    logic [7:0]     data;
    logic           ack;
    logic           ev;
    logic           et;
    logic           el;
    logic [8*N-1:0] exp_line;
  } vec_t;

  vec_t tab[$];
  logic [8*N-1:0] tl;

  function automatic logic [8*N-1:0] mk_line(input string s);
    logic [8*N-1:0] r;
    r = '0;
    for (int i = 0; i < N - 2; i++) begin
      r[8*(N-1-i) +: 8] = (i < s.len()) ? s[i] : 8'h20;
    end
    r[15:0] = 16'h0D0A;
    return r;
  endfunction

  task automatic add(input logic vld, input logic [7:0] data, input logic ack,
                     input logic ev, input logic et, input logic el);
    vec_t v;
    v.vld = vld; v.data = data; v.ack = ack;
    v.ev = ev; v.et = et; v.el = el; v.exp_line = tl;
    tab.push_back(v);
  endtask

  task automatic add_str(input string s, input logic ev, input logic et);
    for (int i = 0; i < s.len(); i++) add(1'b1, s[i], 1'b0, ev, et, 1'b0);
  endtask

  // Trunc is only meaningful while a line is valid, so it is checked only then.
  task automatic check(input string name, input logic ev, input logic et,
                       input logic el, input logic [8*N-1:0] el_line);
    n_vec++;
    if (line_valid !== ev) begin
      $display("FAIL %s valid: got %b want %b", name, line_valid, ev);
      n_miss++;
    end
    if (ev && (line_trunc !== et)) begin
      $display("FAIL %s trunc: got %b want %b", name, line_trunc, et);
      n_miss++;
    end
    if (line_lost !== el) begin
      $display("FAIL %s lost: got %b want %b", name, line_lost, el);
      n_miss++;
    end
    if (line !== el_line) begin
      $display("FAIL %s line: got %h want %h", name, line, el_line);
      n_miss++;
    end
  endtask

  initial begin
    string xs;
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; line_ack = 1'b0;

    // Table: HELLO CR LF, then ack
    tl = mk_line("");
    add_str("HELLO", 1'b0, 1'b0);
    add(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
    tl = mk_line("HELLO");
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Backspace at K=0, control byte, AB BS CR C LF
    add(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    add_str("AB", 1'b0, 1'b0);
    add(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0);
    tl = mk_line("AC");
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // 40 X, backspace while discarding, LF -> 33 X truncated
    for (int i = 0; i < 40; i++) add(1'b1, 8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    xs = "";
    for (int i = 0; i < N - 2; i++) xs = {xs, "X"};
    tl = mk_line(xs);
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Publish A unacked, then B LF is lost for exactly one cycle
    add(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    tl = mk_line("A");
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    // Z LF with same-cycle ack replaces A, no loss
    add(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    tl = mk_line("Z");
    add(1'b1, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_str("QRS", 1'b1, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 1'b0, 1'b0, mk_line(""));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      rx_valid = tab[i].vld;
      rx_data  = tab[i].data;
      line_ack = tab[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tab[i].ev, tab[i].et, tab[i].el, tab[i].exp_line);
    end

    // Asynchronous reset mid-line with Z still published: outputs clear without a clock edge
    rx_valid = 1'b0; rx_data = 8'h00; line_ack = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b0, 1'b0, 1'b0, mk_line(""));
    @(posedge clk);
    #1;
    check("rst_hold", 1'b0, 1'b0, 1'b0, mk_line(""));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b1; rx_data = 8'h54;
    @(posedge clk);
    #1;
    rx_data = 8'h0A;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("after_rst_T", 1'b1, 1'b0, 1'b0, mk_line("T"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
